// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared load/store size codes and a size-class helper used by
//               the load/store unit and its load-alignment datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    // Core access size codes; 3, 6 and 7 are treated as word accesses.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // Access width class, independent of signedness.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Collapse a size code to its width class; unknown codes map to word.
    function automatic logic [1:0] size_class(input logic [2:0] size);
        logic [1:0] cls;
        case (size)
            LDST_B, LDST_BU: cls = SZ_BYTE;
            LDST_H, LDST_HU: cls = SZ_HALF;
            default:         cls = SZ_WORD;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load-data extraction. Selects the addressed
//               byte/half of the memory word and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import memory_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] rd_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select by latched offset, then extend according to the size code.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        rd_o   = mem_rd_i;
        case (offset_i)
            2'd0:    w_byte = mem_rd_i[7:0];
            2'd1:    w_byte = mem_rd_i[15:8];
            2'd2:    w_byte = mem_rd_i[23:16];
            default: w_byte = mem_rd_i[31:24];
        endcase
        w_half = offset_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_i)
            LDST_B:  rd_o = {{24{w_byte[7]}}, w_byte};
            LDST_BU: rd_o = {24'h000000, w_byte};
            LDST_H:  rd_o = {{16{w_half[15]}}, w_half};
            LDST_HU: rd_o = {16'h0000, w_half};
            default: rd_o = mem_rd_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit between the core memory stage and data_mem.
//               Generates byte enables, lane-replicated store data and a
//               one-cycle request pulse, stalls the core until the memory
//               completes and extends load data.
//               Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned
//               H/HU/W accesses are trapped instead of issued).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import memory_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_offset;
    logic [2:0]  r_size;

    logic [1:0]  w_cls;
    logic        w_misalign;
    logic        w_issue;
    logic        w_done;
    logic [31:0] w_align_rd;

    assign w_cls = size_class(core_size_i);

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves must be 2-byte aligned and words 4-byte aligned.
    assign w_misalign = ((w_cls == SZ_HALF) && core_addr_i[0]) ||
                        ((w_cls == SZ_WORD) && (core_addr_i[1:0] != 2'b00));
`else
    // Misaligned accesses are issued using the truncated offset rules.
    assign w_misalign = 1'b0;
`endif

    assign w_issue = (r_state == c_IDLE) && core_req_i && !w_misalign;
    assign w_done  = (r_state == c_BUSY) && mem_ready_i;

    // Handshake outputs are combinational and forced low during reset;
    // mem_rd_i never reaches the stall path.
    assign mem_req_o    = !rst_i && w_issue;
    assign core_stall_o = !rst_i && (w_issue || ((r_state == c_BUSY) && !mem_ready_i));
    assign misalign_o   = !rst_i && (r_state == c_IDLE) && core_req_i && w_misalign;

    assign mem_we_o   = core_we_i;
    assign mem_addr_o = core_addr_i;

    // Byte enables and lane-replicated store data for the current access.
    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
        case (w_cls)
            SZ_BYTE: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            SZ_HALF: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .mem_rd_i (mem_rd_i),
        .offset_i (r_offset),
        .size_i   (r_size),
        .rd_o     (w_align_rd)
    );

    // Load result is only presented in the completion cycle.
    assign core_rd_o = (!rst_i && w_done) ? w_align_rd : 32'h0000_0000;

    // IDLE/BUSY sequencing; offset and size are captured on issue for the
    // load extract in the completion cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_IDLE;
            r_offset <= 2'b00;
            r_size   <= 3'b000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_state  <= c_BUSY;
                        r_offset <= core_addr_i[1:0];
                        r_size   <= core_size_i;
                    end
                end
                default: begin
                    if (mem_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Scoreboard testbench for lsu. Stimulus pushes expected memory
//               requests and load results; a monitor pops and compares them
//               whenever the DUT issues a request or completes an access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_vec  = 0;
    int n_fail = 0;
    logic [68:0] req_q[$];
    logic [31:0] rsp_q[$];
    logic        pending = 1'b0;

    lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from input changes.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                check("rst_req",   {68'd0, mem_req_o},    69'd0);
                check("rst_stall", {68'd0, core_stall_o}, 69'd0);
                check("rst_rd",    {37'd0, core_rd_o},    69'd0);
                check("rst_mis",   {68'd0, misalign_o},   69'd0);
                if (pending) begin
                    void'(rsp_q.pop_front());
                    pending = 1'b0;
                end
            end else if (mem_req_o) begin
                check("req_while_busy", {68'd0, pending}, 69'd0);
                if (req_q.size() == 0) begin
                    check("req_unexpected", 69'd1, 69'd0);
                end else begin
                    check("req_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wd_o}, req_q.pop_front());
                end
                check("req_stall", {68'd0, core_stall_o}, 69'd1);
                pending = 1'b1;
            end else if (pending) begin
                if (mem_ready_i) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 69'd1, 69'd0);
                    end else begin
                        check("load_rd", {37'd0, core_rd_o}, {37'd0, rsp_q.pop_front()});
                    end
                    check("done_stall", {68'd0, core_stall_o}, 69'd0);
                    pending = 1'b0;
                end else begin
                    check("wait_stall", {68'd0, core_stall_o}, 69'd1);
                    check("wait_rd",    {37'd0, core_rd_o},    69'd0);
                end
            end else begin
                check("idle_stall", {68'd0, core_stall_o}, 69'd0);
                check("idle_rd",    {37'd0, core_rd_o},    69'd0);
            end
        end
    end

    // One core access: request cycle, 'waits' low-ready cycles, completion.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                          input logic hold, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'hFFFF_FFFF;
        req_q.push_back({we, exp_be, addr, exp_wd});
        rsp_q.push_back(exp_rd);
        @(posedge clk_i); #1;
        if (!hold) core_req_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk_i); #1;
        end
        mem_ready_i = 1'b1;
        mem_rd_i    = rdata;
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'hFFFF_FFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with a request pending on the core side: everything forced low.
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_0040;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);

        // Stores: byte enables and lane replication.
        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0);
        access(1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0, 0, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access(1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0, 0, 1'b1, 4'b1100, 32'h12341234, 32'h0);

        // Loads from word 0x80F1_7F02.
        access(1'b0, 3'd0, 32'h13, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b1000, 32'h0, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h13, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b1000, 32'h0, 32'h00000080);
        access(1'b0, 3'd1, 32'h12, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b1100, 32'h0, 32'hFFFF80F1);
        access(1'b0, 3'd5, 32'h10, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b0011, 32'h0, 32'h00007F02);
        access(1'b0, 3'd0, 32'h11, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b0010, 32'h0, 32'h0000007F);
        access(1'b0, 3'd1, 32'h10, 32'h0, 32'h80F17F02, 0, 1'b1, 4'b0011, 32'h0, 32'h00007F02);
        // Size code 3 behaves as a word access.
        access(1'b0, 3'd3, 32'h14, 32'h0, 32'hCAFEF00D, 0, 1'b1, 4'b1111, 32'h0, 32'hCAFEF00D);

        // Slow memory, with core_req dropped during BUSY (ignored).
        access(1'b0, 3'd2, 32'h20, 32'h0, 32'h13579BDF, 3, 1'b0, 4'b1111, 32'h0, 32'h13579BDF);

        // Reset while BUSY drops the access.
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h30;
        core_wd_i   = 32'h0;
        req_q.push_back({1'b0, 4'b1111, 32'h30, 32'h0});
        rsp_q.push_back(32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_stall", {68'd0, core_stall_o}, 69'd0);
        check("post_rst_req",   {68'd0, mem_req_o},    69'd0);
        access(1'b0, 3'd2, 32'h34, 32'h0, 32'h0BADF00D, 0, 1'b1, 4'b1111, 32'h0, 32'h0BADF00D);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h21;
        @(negedge clk_i);
        check("mis_flag",  {68'd0, misalign_o},   69'd1);
        check("mis_req",   {68'd0, mem_req_o},    69'd0);
        check("mis_stall", {68'd0, core_stall_o}, 69'd0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("mis_clear", {68'd0, misalign_o}, 69'd0);
`else
        access(1'b0, 3'd2, 32'h21, 32'h0, 32'h11223344, 0, 1'b1, 4'b1111, 32'h0, 32'h11223344);
        @(negedge clk_i);
        check("mis_flag_tied", {68'd0, misalign_o}, 69'd0);
`endif

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("req_q_drained", {37'd0, 32'(req_q.size())}, 69'd0);
        check("rsp_q_drained", {37'd0, 32'(rsp_q.size())}, 69'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit between the core's memory stage and the single-port `data_mem`. Converts a core access (size code plus byte address) into memory byte enables, lane-replicated write data and a one-cycle request pulse. Holds the core with a stall signal until the memory completes. Extracts and sign- or zero-extends load data.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `core_req_i` in 1: the core requests a memory access; held until `core_stall_o` falls.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: access size code (see Operation).
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: load result, extended to 32 bits.
- `core_stall_o` out 1: the core must hold its pipeline and inputs.
- `misalign_o` out 1: misaligned-access pulse; only active when `LSU_MISALIGN_TRAP_EN` is defined.
- `mem_req_o` out 1: request to `data_mem`.
- `mem_we_o` out 1: write enable to `data_mem`.
- `mem_be_o` out 4: byte enables to `data_mem`.
- `mem_addr_o` out 32: address to `data_mem`.
- `mem_wd_o` out 32: write data to `data_mem`.
- `mem_rd_i` in 32: `data_mem` read data; registered by the memory.
- `mem_ready_i` in 1: `data_mem` completion flag.

## Operation
- Size codes:
  - 0 = B (signed byte), 1 = H (signed half), 2 = W (word).
  - 4 = BU (unsigned byte), 5 = HU (unsigned half).
  - Codes 3, 6 and 7 are treated as W.
- FSM states: IDLE and BUSY.
  - IDLE with `core_req_i`=1: `mem_req_o`=1 and `core_stall_o`=1. Latch `core_addr_i[1:0]` and `core_size_i`, then go to BUSY.
  - BUSY: `mem_req_o`=0 and `core_stall_o`=!`mem_ready_i`. When `mem_ready_i`=1, go to IDLE; the access completes in that cycle.
- `mem_we_o`=`core_we_i` and `mem_addr_o`=`core_addr_i`, passed through.
- `mem_be_o` for the access offset:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- `mem_wd_o` lane replication:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd` unchanged.
- Load extract uses the latched offset and size on `mem_rd_i`:
  - B/BU select byte `offset`; H/HU select half `offset[1]`.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- `core_rd_o` is valid only in the completion cycle (BUSY with `mem_ready_i`=1). It is 0 in every other cycle.
- A new request is accepted in IDLE only, so back-to-back accesses take 2 cycles each.

## Timing
- Minimum access latency is 2 cycles: request cycle, then completion cycle.
- If `mem_ready_i`=0 in BUSY, the wait extends one cycle per low-ready cycle. No re-request is issued.
- Reset values: state = IDLE, latched offset/size = 0. While `rst_i`=1, `mem_req_o`, `core_stall_o`, `misalign_o` and `core_rd_o` are forced to 0.
- Reset asserted in BUSY: the FSM returns to IDLE and the pending access is dropped. A store already strobed into memory remains written.
- `core_req_i` falling while in BUSY is ignored; the FSM still completes.
- `core_stall_o` is combinational from state, `core_req_i` and `mem_ready_i`. There is no combinational path from `mem_rd_i` to `core_stall_o`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - For a misaligned access in IDLE: `misalign_o`=1 for one cycle, `mem_req_o`=0, `core_stall_o`=0, and the FSM stays in IDLE.
- Not defined:
  - `misalign_o` is tied to 0.
  - A misaligned access is issued using the truncated offset rules above (H uses addr[1]; W ignores addr[1:0]).

## Structure
- Size-code localparams (`LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU`) go in the shared `memory_pkg`.
- The FSM state enum stays local to `lsu`.
- One combinational sub-module, `lsu_load_align`, takes (`mem_rd_i`, offset, size) and produces `core_rd_o` before gating.
- Store lane logic stays inline.

## Test plan
- SW addr 0x10, wd 0xDEADBEEF:
  - Cycle 0: `mem_req_o`=1, `mem_be_o`=4'b1111, `mem_wd_o`=0xDEADBEEF, `core_stall_o`=1.
  - Cycle 1: stall=0.
- SB addr 0x13, wd 0x000000A5: `mem_be_o`=4'b1000, `mem_wd_o`=0xA5A5A5A5. SH addr 0x12, wd 0x1234: `mem_be_o`=4'b1100, `mem_wd_o`=0x12341234.
- Memory word 0x80F1_7F02:
  - LB at offset 3 gives 0xFFFFFF80; LBU at offset 3 gives 0x00000080.
  - LH at offset 2 gives 0xFFFF80F1; LHU at offset 0 gives 0x00007F02.
- `mem_ready_i` held 0 for 3 cycles after the request: stall stays 1 for 4 cycles total, `mem_req_o` pulses exactly once, and data is valid on the ready cycle.
- `rst_i` asserted in BUSY: the next cycle is IDLE with stall=0 and `mem_req_o`=0. A following LW completes normally in 2 cycles.
- With `LSU_MISALIGN_TRAP_EN` defined, LW at addr 0x21: `misalign_o`=1 for one cycle, `mem_req_o`=0, stall=0. Without the macro, `mem_req_o`=1 and `mem_be_o`=4'b1111.
